// File: rtl/image_scaler_engine_if.sv
// ============================================================================
// Module      : image_scaler_engine_if
// Description : Control handshake, ROM read port and frame-RAM write port of
//               the image scaler. slave = engine side, master = host side.
//               SCALER_PERF_CNT_EN adds the cycles[31:0] performance counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface image_scaler_engine_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 19
);
  logic              start;
  logic [1:0]        mode;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [PIX_W-1:0]  ram_data;
  logic              ram_wren;
`ifdef SCALER_PERF_CNT_EN
  logic [31:0]       cycles;

  modport slave (
    input  start, mode, rom_data,
    output busy, done, err, rom_addr, ram_wraddr, ram_data, ram_wren, cycles
  );
  modport master (
    output start, mode, rom_data,
    input  busy, done, err, rom_addr, ram_wraddr, ram_data, ram_wren, cycles
  );
`else
  modport slave (
    input  start, mode, rom_data,
    output busy, done, err, rom_addr, ram_wraddr, ram_data, ram_wren
  );
  modport master (
    output start, mode, rom_data,
    input  busy, done, err, rom_addr, ram_wraddr, ram_data, ram_wren
  );
`endif
endinterface

`default_nettype wire

// File: rtl/image_scaler_engine.sv
// ============================================================================
// Module      : image_scaler_engine
// Description : ROM-to-frame-RAM scaler. Walks the destination image in raster
//               order, issues one ROM read per RUN cycle, and writes replicated,
//               decimated or block-averaged pixels into the frame RAM after the
//               ROM latency. Optional macro SCALER_PERF_CNT_EN adds a
//               saturating busy-cycle counter on bus.cycles.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module image_scaler_engine #(
  parameter int PIX_W       = 8,
  parameter int SRC_W       = 160,
  parameter int SRC_H       = 120,
  parameter int FACTOR_LOG2 = 1,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = 19
) (
  input  wire logic            clk,
  input  wire logic            reset,
  image_scaler_engine_if.slave bus
);

  localparam int c_factor = 1 << FACTOR_LOG2;
  localparam int c_acc_w  = PIX_W + 2 * FACTOR_LOG2;

  localparam logic [ADDR_W-1:0] c_one    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_fmax   = ADDR_W'(c_factor - 1);
  localparam logic [ADDR_W-1:0] c_src_w  = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] c_dw_up  = ADDR_W'(SRC_W * c_factor);
  localparam logic [ADDR_W-1:0] c_dh_up  = ADDR_W'(SRC_H * c_factor);
  localparam logic [ADDR_W-1:0] c_dw_dn  = ADDR_W'(SRC_W >> FACTOR_LOG2);
  localparam logic [ADDR_W-1:0] c_dh_dn  = ADDR_W'(SRC_H >> FACTOR_LOG2);

  localparam logic [1:0] c_mode_rep = 2'b00;
  localparam logic [1:0] c_mode_avg = 2'b10;
  localparam logic [1:0] c_mode_bad = 2'b11;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_x, r_y, r_dx, r_dy;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_err;

  // Address-phase pipeline; stage i lines up with rom_addr delayed by i clocks
  logic              r_pv [0:ROM_LAT];
  logic              r_pw [0:ROM_LAT];
  logic              r_pf [0:ROM_LAT];
  logic              r_pl [0:ROM_LAT];
  logic [ADDR_W-1:0] r_pa [0:ROM_LAT];

  logic [c_acc_w-1:0] r_acc;
  logic               r_wren;
  logic               r_wr_last;
  logic [ADDR_W-1:0]  r_wraddr;
  logic [PIX_W-1:0]   r_wdata;

  logic              w_idle_like, w_accept, w_reject, w_issue, w_busy;
  logic              w_avg_mode;
  logic              w_dx_last, w_dy_last, w_x_last, w_y_last;
  logic              w_blk_first, w_blk_last, w_frame_last;
  logic [ADDR_W-1:0] w_dw, w_dh;
  logic [ADDR_W-1:0] w_ra, w_wa;
  logic [c_acc_w-1:0] w_acc_sum, w_acc_shr;

  assign w_idle_like = (r_state == c_st_idle) || (r_state == c_st_done);
  assign w_accept    = w_idle_like && bus.start && (bus.mode != c_mode_bad);
  assign w_reject    = w_idle_like && bus.start && (bus.mode == c_mode_bad);
  assign w_issue     = (r_state == c_st_run);
  assign w_busy      = (r_state == c_st_run) || (r_state == c_st_drain);
  assign w_avg_mode  = (r_mode == c_mode_avg);

  // Destination size depends on the mode: upscaled for replicate, reduced otherwise
  assign w_dw = (r_mode == c_mode_rep) ? c_dw_up : c_dw_dn;
  assign w_dh = (r_mode == c_mode_rep) ? c_dh_up : c_dh_dn;

  assign w_dx_last    = !w_avg_mode || (r_dx == c_fmax);
  assign w_dy_last    = !w_avg_mode || (r_dy == c_fmax);
  assign w_x_last     = (r_x == w_dw - c_one);
  assign w_y_last     = (r_y == w_dh - c_one);
  assign w_blk_first  = !w_avg_mode || ((r_dx == '0) && (r_dy == '0));
  assign w_blk_last   = w_dx_last && w_dy_last;
  assign w_frame_last = w_blk_last && w_x_last && w_y_last;

  // Decimate is the average walk with dx=dy=0, so both share one formula
  assign w_ra = (r_mode == c_mode_rep)
              ? (r_y >> FACTOR_LOG2) * c_src_w + (r_x >> FACTOR_LOG2)
              : ((r_y << FACTOR_LOG2) + r_dy) * c_src_w + ((r_x << FACTOR_LOG2) + r_dx);
  assign w_wa = r_y * w_dw + r_x;

  assign w_acc_sum = (r_pf[ROM_LAT] ? '0 : r_acc) + c_acc_w'(bus.rom_data);
  assign w_acc_shr = w_acc_sum >> (2 * FACTOR_LOG2);

  // Control FSM, coordinate walk and ROM address register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_mode     <= 2'b00;
      r_x        <= '0;
      r_y        <= '0;
      r_dx       <= '0;
      r_dy       <= '0;
      r_rom_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (w_accept) begin
            r_state <= c_st_run;
            r_mode  <= bus.mode;
            r_x     <= '0;
            r_y     <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
          end
        end
        c_st_run: begin
          r_rom_addr <= w_ra;
          if (w_frame_last) r_state <= c_st_drain;
          if (!w_dx_last) begin
            r_dx <= r_dx + c_one;
          end else begin
            r_dx <= '0;
            if (!w_dy_last) begin
              r_dy <= r_dy + c_one;
            end else begin
              r_dy <= '0;
              if (!w_x_last) begin
                r_x <= r_x + c_one;
              end else begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + c_one;
              end
            end
          end
        end
        c_st_drain: begin
          if (r_wr_last) r_state <= c_st_done;
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  // Delay the address-phase tags by ROM_LAT so they meet the returning rom_data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pw[i] <= 1'b0;
        r_pf[i] <= 1'b0;
        r_pl[i] <= 1'b0;
        r_pa[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_issue;
      r_pw[0] <= w_issue && w_blk_last;
      r_pf[0] <= w_blk_first;
      r_pl[0] <= w_issue && w_frame_last;
      r_pa[0] <= w_wa;
      for (int i = 1; i <= ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pw[i] <= r_pw[i-1];
        r_pf[i] <= r_pf[i-1];
        r_pl[i] <= r_pl[i-1];
        r_pa[i] <= r_pa[i-1];
      end
    end
  end

  // Block accumulator and registered frame-RAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc     <= '0;
      r_wren    <= 1'b0;
      r_wr_last <= 1'b0;
      r_wraddr  <= '0;
      r_wdata   <= '0;
    end else begin
      r_wren    <= r_pw[ROM_LAT];
      r_wr_last <= r_pl[ROM_LAT];
      if (r_pv[ROM_LAT]) begin
        r_acc <= w_acc_sum;
        if (r_pw[ROM_LAT]) begin
          r_wraddr <= r_pa[ROM_LAT];
          r_wdata  <= w_avg_mode ? w_acc_shr[PIX_W-1:0] : bus.rom_data;
        end
      end
    end
  end

  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == c_st_done);
  assign bus.err        = r_err;
  assign bus.rom_addr   = r_rom_addr;
  assign bus.ram_wraddr = r_wraddr;
  assign bus.ram_data   = r_wdata;
  assign bus.ram_wren   = r_wren;

`ifdef SCALER_PERF_CNT_EN
  logic [31:0] r_cycles;

  // Saturating count of busy clocks, restarted by each accepted start
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles <= '0;
    end else if (w_accept) begin
      r_cycles <= '0;
    end else if (w_busy && (r_cycles != 32'hFFFF_FFFF)) begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign bus.cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_image_scaler_engine.sv
// ============================================================================
// Module      : tb_image_scaler_engine
// Description : Directed scoreboard bench for image_scaler_engine with a 4x4
//               source, factor 2 and two-clock ROM latency.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_image_scaler_engine;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk;
  logic reset;

  image_scaler_engine_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  image_scaler_engine #(
    .PIX_W(PIX_W), .SRC_W(4), .SRC_H(4), .FACTOR_LOG2(1), .ROM_LAT(2), .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] rom [16];
  logic [7:0] ram_m [64];
  logic [7:0] rd0, rd1;

  wr_t sb [$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_wr_cyc = 0;
  int  wr_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // two-clock ROM model
  always @(posedge clk) begin
    rd0 <= rom[bus.rom_addr[3:0]];
    rd1 <= rd0;
  end
  assign bus.rom_data = rd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // write monitor: pops the scoreboard on every RAM write
  always @(negedge clk) begin
    cyc++;
    if (bus.ram_wren === 1'b1) begin
      last_wr_cyc = cyc;
      wr_cnt++;
      chk("busy_during_write", 32'(bus.busy), 1);
      chk("write_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(bus.ram_wraddr), 32'(mon_e.a));
        chk("wr_data", 32'(bus.ram_data), 32'(mon_e.d));
      end
      if (bus.ram_wraddr < 8'd64) ram_m[bus.ram_wraddr[5:0]] = bus.ram_data;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [1:0] m);
    wr_t e;
    int  s;
    if (m == 2'b00) begin
      for (int y = 0; y < 8; y++)
        for (int x = 0; x < 8; x++) begin
          e.a = 8'(y * 8 + x);
          e.d = rom[(y / 2) * 4 + (x / 2)];
          sb.push_back(e);
        end
    end else begin
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 2; x++) begin
          e.a = 8'(y * 2 + x);
          if (m == 2'b01) begin
            e.d = rom[(2 * y) * 4 + 2 * x];
          end else begin
            s = int'(rom[(2 * y) * 4 + 2 * x]) + int'(rom[(2 * y) * 4 + 2 * x + 1])
              + int'(rom[(2 * y + 1) * 4 + 2 * x]) + int'(rom[(2 * y + 1) * 4 + 2 * x + 1]);
            e.d = 8'(s / 4);
          end
          sb.push_back(e);
        end
    end
  endtask

  task automatic pulse_start(input logic [1:0] m);
    bus.start = 1'b1;
    bus.mode  = m;
    step();
    bus.start = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m);
    for (int i = 0; i < 64; i++) ram_m[i] = 8'hEE;
    push_frame(m);
    wr_cnt = 0;
    pulse_start(m);
    chk("busy_after_start", 32'(bus.busy), 1);
    chk("done_cleared", 32'(bus.done), 0);
  endtask

  task automatic finish_frame(input int exp_wr);
    int n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    chk("done_reached", 32'(bus.done), 1);
    chk("done_after_last_wr", cyc, last_wr_cyc + 1);
    chk("busy_low_at_done", 32'(bus.busy), 0);
    chk("wr_count", wr_cnt, exp_wr);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 16);
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    repeat (3) step();

    // reset state
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_wren", 32'(bus.ram_wren), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    reset = 1'b0;
    step();

    // reserved mode in IDLE
    pulse_start(2'b11);
    chk("t4_err_high", 32'(bus.err), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    chk("t4_done", 32'(bus.done), 0);
    chk("t4_wren", 32'(bus.ram_wren), 0);
    step();
    chk("t4_err_one_cycle", 32'(bus.err), 0);
    chk("t4_busy_after", 32'(bus.busy), 0);
    chk("t4_done_after", 32'(bus.done), 0);

    // replicate
    start_frame(2'b00);
    finish_frame(64);
    chk("t1_ram0", 32'(ram_m[0]), 32'h00);
    chk("t1_ram1", 32'(ram_m[1]), 32'h00);
    chk("t1_ram8", 32'(ram_m[8]), 32'h00);
    chk("t1_ram9", 32'(ram_m[9]), 32'h00);
    chk("t1_ram2", 32'(ram_m[2]), 32'h10);
    chk("t1_ram63", 32'(ram_m[63]), 32'hF0);

    // start while busy is ignored
    start_frame(2'b00);
    repeat (5) step();
    pulse_start(2'b01);
    chk("t5_no_err", 32'(bus.err), 0);
    chk("t5_still_busy", 32'(bus.busy), 1);
    finish_frame(64);
    chk("t5_ram63", 32'(ram_m[63]), 32'hF0);
    chk("t5_ram2", 32'(ram_m[2]), 32'h10);

    // decimate
    start_frame(2'b01);
    finish_frame(4);
    chk("t2_ram0", 32'(ram_m[0]), 32'h00);
    chk("t2_ram1", 32'(ram_m[1]), 32'h20);
    chk("t2_ram2", 32'(ram_m[2]), 32'h80);
    chk("t2_ram3", 32'(ram_m[3]), 32'hA0);
    chk("t2_ram4_untouched", 32'(ram_m[4]), 32'hEE);

    // average with truncation
    rom[0] = 8'd10;
    rom[1] = 8'd20;
    rom[4] = 8'd30;
    rom[5] = 8'd41;
    start_frame(2'b10);
    finish_frame(4);
    chk("t3_ram0", 32'(ram_m[0]), 32'd25);
    chk("t3_ram3", 32'(ram_m[3]), 32'(((10 + 11 + 14 + 15) * 16) / 4));
    for (int i = 0; i < 16; i++) rom[i] = 8'(i * 16);

    // reset mid-frame
    start_frame(2'b00);
    repeat (20) step();
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    step();
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_done", 32'(bus.done), 0);
    chk("t6_err", 32'(bus.err), 0);
    chk("t6_wren", 32'(bus.ram_wren), 0);
    chk("t6_rom_addr", 32'(bus.rom_addr), 0);
    chk("t6_wraddr", 32'(bus.ram_wraddr), 0);
    chk("t6_wdata", 32'(bus.ram_data), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_wren_in_reset", 32'(bus.ram_wren), 0);
    end
    reset = 1'b0;
    step();
    start_frame(2'b00);
    finish_frame(64);
    chk("t6_ram2", 32'(ram_m[2]), 32'h10);
    chk("t6_ram63", 32'(ram_m[63]), 32'hF0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
